// File: rtl/ctrl_pipe_regs_pkg.sv
// ctrl_pipe_pkg: shared widths, control-bundle bit positions, bubble value
// and forwarding-select encodings for the ID->EX->MEM->WB control pipeline.
package ctrl_pipe_pkg;

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned REG_W  = 5;

  // Bit positions inside the decoder's control bundle.
  localparam int unsigned CTRL_REGDST   = 8;
  localparam int unsigned CTRL_ALUOP_HI = 7;
  localparam int unsigned CTRL_ALUOP_LO = 6;
  localparam int unsigned CTRL_ALUSRC   = 5;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [REG_W-1:0]  reg_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // True when a writing stage targets src; $0 never matches.
  function automatic logic reg_hit(input logic wr, input reg_t wreg, input reg_t src);
    return wr && (wreg != '0) && (wreg == src);
  endfunction

endpackage

// File: rtl/ctrl_pipe_regs_if.sv
// ctrl_pipe_regs_if: decoder -> control-pipeline bundle for the instruction
// currently in ID.
//   id_ctrl        9-bit control bundle from the opcode decoder
//   id_rs/rt/rd    register fields of the instruction in ID
// master = decoder side, slave = ctrl_pipe_regs.
interface ctrl_pipe_regs_if import ctrl_pipe_pkg::*; ();
  ctrl_t id_ctrl;
  reg_t  id_rs;
  reg_t  id_rt;
  reg_t  id_rd;

  modport master (output id_ctrl, id_rs, id_rt, id_rd);
  modport slave  (input  id_ctrl, id_rs, id_rt, id_rd);
endinterface

// File: rtl/ctrl_pipe_regs_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational stall and EX operand-forwarding selects.
//   id_rs/id_rt         source registers of the instruction in ID
//   ex_memread/_regwrite, ex_wreg, ex_rs, ex_rt   EX-stage state
//   mem_regwrite, mem_wreg / wb_regwrite, wb_wreg  later-stage writers
//   stall               hold PC/IF-ID and bubble ID/EX
//   fwd_a / fwd_b       source select for ex_rs / ex_rt
// Macro CTRL_PIPE_FWD_EN: defined -> forwarding plus load-use stall only;
// undefined -> no forwarding, stall on any EX/MEM writer matching ID sources.
module hazard_fwd_unit import ctrl_pipe_pkg::*; (
  input  reg_t     id_rs,
  input  reg_t     id_rt,
  input  logic     ex_memread,
  input  logic     ex_regwrite,
  input  reg_t     ex_wreg,
  input  reg_t     ex_rs,
  input  reg_t     ex_rt,
  input  logic     mem_regwrite,
  input  reg_t     mem_wreg,
  input  logic     wb_regwrite,
  input  reg_t     wb_wreg,
  output logic     stall,
  output fwd_sel_e fwd_a,
  output fwd_sel_e fwd_b
);

`ifdef CTRL_PIPE_FWD_EN
  logic unused_inputs;
  assign unused_inputs = ex_regwrite;

  // Load-use: gated on MemRead only; rt compared even if unused as a source.
  always_comb begin
    stall = reg_hit(ex_memread, ex_wreg, id_rs) | reg_hit(ex_memread, ex_wreg, id_rt);
  end

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (reg_hit(mem_regwrite, mem_wreg, ex_rs))     fwd_a = FWD_MEM;
    else if (reg_hit(wb_regwrite, wb_wreg, ex_rs))  fwd_a = FWD_WB;
    if (reg_hit(mem_regwrite, mem_wreg, ex_rt))     fwd_b = FWD_MEM;
    else if (reg_hit(wb_regwrite, wb_wreg, ex_rt))  fwd_b = FWD_WB;
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{ex_memread, ex_rs, ex_rt, wb_regwrite, wb_wreg};

  // WB is not checked: the regfile writes in the first half-cycle.
  always_comb begin
    stall = reg_hit(ex_regwrite, ex_wreg, id_rs)   | reg_hit(ex_regwrite, ex_wreg, id_rt) |
            reg_hit(mem_regwrite, mem_wreg, id_rs) | reg_hit(mem_regwrite, mem_wreg, id_rt);
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
  end
`endif

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: carries the decoder control bundle through EX/MEM/WB,
// owns stall, flush and bubble decisions, resolves branches in MEM.
//   clk, rst_n          clock, asynchronous active-low reset
//   id                  decoder bundle + register fields (slave modport)
//   ex_zero             ALU zero flag of the instruction in EX
//   ex/mem/wb_ctrl      registered control bundle per stage
//   ex/mem/wb_wreg      destination register per stage
//   pc_write, ifid_write  0 = stall
//   ifid_flush          zero IF/ID at the next edge
//   pc_src              take the branch target
//   fwd_a, fwd_b        EX operand source (00 regfile, 10 MEM, 01 WB)
// Macro CTRL_PIPE_FWD_EN selects forwarding (see hazard_fwd_unit).
module ctrl_pipe_regs import ctrl_pipe_pkg::*; (
  input  logic                   clk,
  input  logic                   rst_n,
  ctrl_pipe_regs_if.slave        id,
  input  logic                   ex_zero,
  output ctrl_t                  ex_ctrl,
  output ctrl_t                  mem_ctrl,
  output ctrl_t                  wb_ctrl,
  output reg_t                   ex_wreg,
  output reg_t                   mem_wreg,
  output reg_t                   wb_wreg,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   pc_src,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b
);

  reg_t     ex_rs, ex_rt, ex_rd;
  logic     mem_zero;
  logic     stall;
  logic     stall_eff;
  fwd_sel_e fwd_a_sel, fwd_b_sel;

  assign ex_wreg = ex_ctrl[CTRL_REGDST] ? ex_rd : ex_rt;
  assign pc_src  = mem_ctrl[CTRL_BRANCH] & mem_zero;

  hazard_fwd_unit u_hazard (
    .id_rs        (id.id_rs),
    .id_rt        (id.id_rt),
    .ex_memread   (ex_ctrl[CTRL_MEMREAD]),
    .ex_regwrite  (ex_ctrl[CTRL_REGWRITE]),
    .ex_wreg      (ex_wreg),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_regwrite (mem_ctrl[CTRL_REGWRITE]),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_ctrl[CTRL_REGWRITE]),
    .wb_wreg      (wb_wreg),
    .stall        (stall),
    .fwd_a        (fwd_a_sel),
    .fwd_b        (fwd_b_sel)
  );

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

  // A taken branch squashes the ID instruction anyway, so its stall is moot.
  assign stall_eff  = stall & ~pc_src;
  assign pc_write   = ~stall_eff;
  assign ifid_write = ~stall_eff;
  assign ifid_flush = pc_src;

  // ID/EX: register fields are zeroed with the bubble so ex_wreg reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else if (pc_src || stall) begin
      ex_ctrl <= CTRL_BUBBLE;
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
    end else begin
      ex_ctrl <= id.id_ctrl;
      ex_rs   <= id.id_rs;
      ex_rt   <= id.id_rt;
      ex_rd   <= id.id_rd;
    end
  end

  // EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl <= CTRL_BUBBLE;
      mem_wreg <= '0;
      mem_zero <= 1'b0;
    end else if (pc_src) begin
      mem_ctrl <= CTRL_BUBBLE;
      mem_wreg <= '0;
      mem_zero <= 1'b0;
    end else begin
      mem_ctrl <= ex_ctrl;
      mem_wreg <= ex_wreg;
      mem_zero <= ex_zero;
    end
  end

  // MEM/WB: always advances; a resolving branch has RegWrite=0 by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctrl <= CTRL_BUBBLE;
      wb_wreg <= '0;
    end else begin
      wb_ctrl <= mem_ctrl;
      wb_wreg <= mem_wreg;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
module tb_ctrl_pipe_regs;
  import ctrl_pipe_pkg::*;

`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ex_zero;
  logic [8:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic pc_write, ifid_write, ifid_flush, pc_src;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_regs_if bus ();

  ctrl_pipe_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id         (bus),
    .ex_zero    (ex_zero),
    .ex_ctrl    (ex_ctrl),
    .mem_ctrl   (mem_ctrl),
    .wb_ctrl    (wb_ctrl),
    .ex_wreg    (ex_wreg),
    .mem_wreg   (mem_wreg),
    .wb_wreg    (wb_wreg),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush),
    .pc_src     (pc_src),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  // Reference model: one record per in-flight instruction.
  typedef struct packed {
    logic [8:0] ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       zero;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic logic writes(input instr_t s, input logic [4:0] r);
    return s.ctrl[1] && (s.dst != 5'd0) && (s.dst == r);
  endfunction

  function automatic logic m_flush();
    return m_mem.ctrl[4] && m_mem.zero;
  endfunction

  function automatic logic m_hazard(input logic [4:0] rs, input logic [4:0] rt);
    if (FWD)
      return m_ex.ctrl[3] && (m_ex.dst != 5'd0) && (m_ex.dst == rs || m_ex.dst == rt);
    else
      return writes(m_ex, rs) || writes(m_ex, rt) || writes(m_mem, rs) || writes(m_mem, rt);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (!FWD)              return 2'b00;
    if (writes(m_mem, r))  return 2'b10;
    if (writes(m_wb, r))   return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
  endfunction

  function automatic void model_clock();
    logic fl, hz;
    fl = m_flush();
    hz = m_hazard(bus.id_rs, bus.id_rt);
    m_wb = m_mem;
    if (fl) m_mem = '0;
    else begin
      m_mem = m_ex;
      m_mem.zero = ex_zero;
    end
    if (fl || hz) m_ex = '0;
    else begin
      m_ex.ctrl = bus.id_ctrl;
      m_ex.rs   = bus.id_rs;
      m_ex.rt   = bus.id_rt;
      m_ex.dst  = bus.id_ctrl[8] ? bus.id_rd : bus.id_rt;
      m_ex.zero = 1'b0;
    end
  endfunction

  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
    bus.id_ctrl = c;
    bus.id_rs   = rs;
    bus.id_rt   = rt;
    bus.id_rd   = rd;
    ex_zero     = z;
  endtask

  // Called at posedge+1 or later, before the next edge.
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    checks++; if (ex_ctrl !== 9'h000 || wb_ctrl !== 9'h000) begin errors++;
      $display("FAIL reset_init: ex_ctrl=%0h wb_ctrl=%0h expected 0", ex_ctrl, wb_ctrl); end
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(9'h182, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    tick();
    // Stages now hold live data; reset without a clock edge.
    rst_n = 1'b0;
    #1;
    checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 27'd0) begin errors++;
      $display("FAIL reset_ctrl: got %0h/%0h/%0h expected 0/0/0", ex_ctrl, mem_ctrl, wb_ctrl); end
    checks++; if ({ex_wreg, mem_wreg, wb_wreg} !== 15'd0) begin errors++;
      $display("FAIL reset_wreg: got %0d/%0d/%0d expected 0/0/0", ex_wreg, mem_wreg, wb_wreg); end
    checks++; if ({pc_write, ifid_write, ifid_flush, pc_src} !== 4'b1100) begin errors++;
      $display("FAIL reset_hazard: pcw/ifw/flush/pcsrc=%b expected 1100",
               {pc_write, ifid_write, ifid_flush, pc_src}); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++;
      $display("FAIL reset_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rtype();
    do_reset();
    drive(9'h182, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ex_ctrl !== 9'h182 || ex_wreg !== 5'd5) begin errors++;
      $display("FAIL rtype_ex: got %0h/%0d expected 182/5", ex_ctrl, ex_wreg); end
    tick();
    checks++; if (mem_ctrl !== 9'h182 || mem_wreg !== 5'd5) begin errors++;
      $display("FAIL rtype_mem: got %0h/%0d expected 182/5", mem_ctrl, mem_wreg); end
    tick();
    checks++; if (wb_ctrl !== 9'h182 || wb_wreg !== 5'd5) begin errors++;
      $display("FAIL rtype_wb: got %0h/%0d expected 182/5", wb_ctrl, wb_wreg); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(9'h02B, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drive(9'h182, 5'd8, 5'd3, 5'd4, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++;
      $display("FAIL loaduse_stall: pcw/ifw=%b%b expected 00", pc_write, ifid_write); end
    tick();
    checks++; if (ex_ctrl !== 9'h000) begin errors++;
      $display("FAIL loaduse_bubble: ex_ctrl=%0h expected 0", ex_ctrl); end
    checks++; if (pc_write !== FWD) begin errors++;
      $display("FAIL loaduse_release: pc_write=%b expected %b", pc_write, FWD); end
    // Load targeting $0 never stalls.
    do_reset();
    drive(9'h02B, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(9'h182, 5'd0, 5'd0, 5'd4, 1'b0);
    #1;
    checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++;
      $display("FAIL loaduse_r0: pcw/ifw=%b%b expected 11", pc_write, ifid_write); end
  endtask

  task automatic test_forward();
    // Producer in MEM only.
    do_reset();
    drive(9'h182, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    drive(9'h182, 5'd9, 5'd3, 5'd10, 1'b0);
    #1;
    checks++; if (pc_write !== FWD) begin errors++;
      $display("FAIL fwd_mem_stall: pc_write=%b expected %b", pc_write, FWD); end
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (fwd_a !== (FWD ? 2'b10 : 2'b00) || fwd_b !== 2'b00) begin errors++;
      $display("FAIL fwd_mem: got %b/%b expected %b/00", fwd_a, fwd_b, FWD ? 2'b10 : 2'b00); end
    // Producer in WB only.
    do_reset();
    drive(9'h182, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(9'h182, 5'd9, 5'd9, 5'd10, 1'b0);
    #1;
    checks++; if (pc_write !== FWD) begin errors++;
      $display("FAIL fwd_wb_stall: pc_write=%b expected %b", pc_write, FWD); end
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== (FWD ? 2'b01 : 2'b00)) begin errors++;
      $display("FAIL fwd_wb: got %b/%b expected %b", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00); end
    // Both MEM and WB write $9: MEM wins.
    do_reset();
    drive(9'h182, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    drive(9'h182, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    drive(9'h182, 5'd9, 5'd3, 5'd10, 1'b0);
    #1;
    checks++; if (pc_write !== FWD) begin errors++;
      $display("FAIL fwd_both_stall: pc_write=%b expected %b", pc_write, FWD); end
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (fwd_a !== (FWD ? 2'b10 : 2'b00)) begin errors++;
      $display("FAIL fwd_both: fwd_a=%b expected %b", fwd_a, FWD ? 2'b10 : 2'b00); end
  endtask

  task automatic test_branch();
    for (int taken = 1; taken >= 0; taken--) begin
      do_reset();
      drive(9'h050, 5'd1, 5'd2, 5'd0, 1'b0);
      tick();
      drive(9'h182, 5'd1, 5'd2, 5'd6, taken[0]);
      #1;
      checks++; if (pc_src !== 1'b0) begin errors++;
        $display("FAIL branch_early: pc_src=%b expected 0", pc_src); end
      tick();
      drive(9'h182, 5'd1, 5'd2, 5'd7, 1'b0);
      #1;
      checks++; if (pc_src !== taken[0] || ifid_flush !== taken[0] || pc_write !== 1'b1) begin errors++;
        $display("FAIL branch_resolve: pc_src/flush/pcw=%b%b%b expected %b%b1",
                 pc_src, ifid_flush, pc_write, taken[0], taken[0]); end
      tick();
      drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      if (taken != 0) begin
        checks++; if (ex_ctrl !== 9'h000 || mem_ctrl !== 9'h000 || wb_ctrl !== 9'h050) begin errors++;
          $display("FAIL branch_squash: ex/mem/wb=%0h/%0h/%0h expected 0/0/50", ex_ctrl, mem_ctrl, wb_ctrl); end
      end else begin
        checks++; if (ex_ctrl !== 9'h182 || mem_ctrl !== 9'h182) begin errors++;
          $display("FAIL branch_not_taken: ex/mem=%0h/%0h expected 182/182", ex_ctrl, mem_ctrl); end
      end
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(9'h050, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(9'h02B, 5'd1, 5'd8, 5'd0, 1'b1);
    tick();
    drive(9'h182, 5'd8, 5'd2, 5'd4, 1'b0);
    #1;
    checks++; if ({pc_write, ifid_write, ifid_flush, pc_src} !== 4'b1111) begin errors++;
      $display("FAIL flush_stall: pcw/ifw/flush/pcsrc=%b expected 1111",
               {pc_write, ifid_write, ifid_flush, pc_src}); end
    tick();
    drive(9'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (ex_ctrl !== 9'h000 || mem_ctrl !== 9'h000) begin errors++;
      $display("FAIL flush_stall_bubble: ex/mem=%0h/%0h expected 0/0", ex_ctrl, mem_ctrl); end
  endtask

  task automatic test_random();
    logic [8:0] c;
    logic       ef, eh;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: c = 9'h182;
        1: c = 9'h02B;
        2: c = 9'h024;
        3: c = 9'h050;
        4: c = 9'h022;
        5: c = 9'h000;
        default: c = 9'($urandom);
      endcase
      drive(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom));
      #1;
      ef = m_flush();
      eh = m_hazard(bus.id_rs, bus.id_rt);
      checks++; if (ex_ctrl !== m_ex.ctrl || ex_wreg !== m_ex.dst) begin errors++;
        $display("FAIL rnd_ex[%0d]: got %0h/%0d expected %0h/%0d", i, ex_ctrl, ex_wreg, m_ex.ctrl, m_ex.dst); end
      checks++; if (mem_ctrl !== m_mem.ctrl || mem_wreg !== m_mem.dst) begin errors++;
        $display("FAIL rnd_mem[%0d]: got %0h/%0d expected %0h/%0d", i, mem_ctrl, mem_wreg, m_mem.ctrl, m_mem.dst); end
      checks++; if (wb_ctrl !== m_wb.ctrl || wb_wreg !== m_wb.dst) begin errors++;
        $display("FAIL rnd_wb[%0d]: got %0h/%0d expected %0h/%0d", i, wb_ctrl, wb_wreg, m_wb.ctrl, m_wb.dst); end
      checks++; if (pc_src !== ef || ifid_flush !== ef) begin errors++;
        $display("FAIL rnd_branch[%0d]: pc_src/flush=%b%b expected %b%b", i, pc_src, ifid_flush, ef, ef); end
      checks++; if (pc_write !== !(eh && !ef) || ifid_write !== !(eh && !ef)) begin errors++;
        $display("FAIL rnd_stall[%0d]: pcw/ifw=%b%b expected %b", i, pc_write, ifid_write, !(eh && !ef)); end
      checks++; if (fwd_a !== m_fwd(m_ex.rs) || fwd_b !== m_fwd(m_ex.rt)) begin errors++;
        $display("FAIL rnd_fwd[%0d]: got %b/%b expected %b/%b", i, fwd_a, fwd_b, m_fwd(m_ex.rs), m_fwd(m_ex.rt)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_forward();
    test_branch();
    test_flush_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
